// File: rtl/cordic_quad_pkg.sv
// Shared constants and helpers for the CORDIC vectoring quadrant capture/correct pair.
// Quadrant tags are {y_msb, x_msb} of the vector as it entered the core.
package cordic_quad_pkg;

    localparam logic [1:0] QUAD_PP = 2'b00;
    localparam logic [1:0] QUAD_NP = 2'b01;
    localparam logic [1:0] QUAD_NN = 2'b11;
    localparam logic [1:0] QUAD_PN = 2'b10;

    // CORDIC gain 0.607253 as Q(W-1); this is the value at W=16
    localparam logic [15:0] CORDIC_K_W16 = 16'h4DBA;

    // Binary-angle pi: 2^(W-1)
    function automatic logic [63:0] angle_pi(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // round(0.607253 * 2^(w-1)), integer-only so it elaborates anywhere
    function automatic logic [63:0] cordic_k(input int w);
        return (64'd607253 * (64'd1 << (w - 1)) + 64'd500000) / 64'd1000000;
    endfunction

endpackage

// File: rtl/vec_quad_correct_if.sv
// Handshake/data bundle between the CORDIC vectoring output and the quadrant corrector.
interface vec_quad_correct_if #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          enable;
    logic          tag_valid;
    logic [1:0]    tag_quad;
    logic          res_valid;
    logic [W-1:0]  res_angle;
    logic [W-1:0]  res_mag;
    logic          clear_err;
    logic          out_valid;
    logic [W-1:0]  out_angle;
    logic [W-1:0]  out_mag;
    logic [1:0]    out_quad;
    logic [CW-1:0] fifo_count;
    logic          err_overflow;
    logic          err_underflow;

    modport slave (
        input  enable, tag_valid, tag_quad, res_valid, res_angle, res_mag, clear_err,
        output out_valid, out_angle, out_mag, out_quad, fifo_count, err_overflow, err_underflow
    );

    modport master (
        output enable, tag_valid, tag_quad, res_valid, res_angle, res_mag, clear_err,
        input  out_valid, out_angle, out_mag, out_quad, fifo_count, err_overflow, err_underflow
    );
endinterface

// File: rtl/quad_tag_fifo.sv
// In-order queue of quadrant tags with occupancy count and sticky over/underflow flags.
// Push and pop in the same cycle never bypass: an empty queue always underflows.
module quad_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          enable_i,
    input  logic          push_i,
    input  logic [1:0]    tag_i,
    input  logic          pop_i,
    input  logic          clear_err_i,
    output logic          pop_ok_o,
    output logic [1:0]    pop_tag_o,
    output logic [CW-1:0] count_o,
    output logic          err_overflow_o,
    output logic          err_underflow_o
);
    logic [DEPTH-1:0][1:0] mem_q;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  full, empty, do_push, do_pop, new_ovf, new_unf;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = enable_i & pop_i & ~empty;
    // A pop frees the slot, so a full queue still accepts a simultaneous push
    assign do_push = enable_i & push_i & (~full | do_pop);
    assign new_ovf = enable_i & push_i & full & ~do_pop;
    assign new_unf = enable_i & pop_i & empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = (ovf_q & ~clear_err_i) | new_ovf;
        unf_d = (unf_q & ~clear_err_i) | new_unf;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= tag_i;
    end

    assign pop_ok_o        = do_pop;
    assign pop_tag_o       = mem_q[rptr_q];
    assign count_o         = count_q;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;
endmodule

// File: rtl/vec_quad_correct.sv
// Pairs CORDIC vectoring results with their captured quadrant and maps angle to [-pi, pi).
// Optional QUAD_GAIN_COMP_EN adds a registered CORDIC-gain multiply on magnitude (latency 2).
module vec_quad_correct
    import cordic_quad_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input logic               clk,
    input logic               nreset,
    vec_quad_correct_if.slave bus
);
`ifdef QUAD_GAIN_COMP_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam logic [W-1:0] PI = W'(angle_pi(W));

    logic [STAGES:0] vld_pipe;
    logic [1:0]      pop_tag;
    logic [W-1:0]    ang_d;
    logic [W-1:0]    ang1_q, mag1_q;
    logic [1:0]      quad1_q;

    quad_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk             (clk),
        .nreset          (nreset),
        .enable_i        (bus.enable),
        .push_i          (bus.tag_valid),
        .tag_i           (bus.tag_quad),
        .pop_i           (bus.res_valid),
        .clear_err_i     (bus.clear_err),
        .pop_ok_o        (vld_pipe[0]),
        .pop_tag_o       (pop_tag),
        .count_o         (bus.fifo_count),
        .err_overflow_o  (bus.err_overflow),
        .err_underflow_o (bus.err_underflow)
    );

    always_comb begin
        ang_d = bus.res_angle;
        case (pop_tag)
            QUAD_PP: ang_d = bus.res_angle;
            QUAD_NP: ang_d = PI - bus.res_angle;
            QUAD_NN: ang_d = bus.res_angle - PI;
            QUAD_PN: ang_d = '0 - bus.res_angle;
            default: ang_d = bus.res_angle;
        endcase
    end

    // Middle stages hold while disabled; only the output valid is forced low
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_pipe[1] <= 1'b0;
            ang1_q      <= '0;
            mag1_q      <= '0;
            quad1_q     <= '0;
        end else if (bus.enable) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                ang1_q  <= ang_d;
                mag1_q  <= bus.res_mag;
                quad1_q <= pop_tag;
            end
        end else begin
            vld_pipe[1] <= (STAGES > 1) ? vld_pipe[1] : 1'b0;
        end
    end

`ifdef QUAD_GAIN_COMP_EN
    localparam logic [W-1:0] K = W'(cordic_k(W));

    logic [2*W-1:0] prod;
    logic [W-1:0]   ang2_q, mag2_q;
    logic [1:0]     quad2_q;

    assign prod = {{W{1'b0}}, mag1_q} * {{W{1'b0}}, K};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_pipe[2] <= 1'b0;
            ang2_q      <= '0;
            mag2_q      <= '0;
            quad2_q     <= '0;
        end else if (bus.enable) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                ang2_q  <= ang1_q;
                mag2_q  <= prod[2*W-2:W-1];
                quad2_q <= quad1_q;
            end
        end else begin
            vld_pipe[2] <= 1'b0;
        end
    end

    assign bus.out_valid = vld_pipe[2];
    assign bus.out_angle = ang2_q;
    assign bus.out_mag   = mag2_q;
    assign bus.out_quad  = quad2_q;
`else
    assign bus.out_valid = vld_pipe[1];
    assign bus.out_angle = ang1_q;
    assign bus.out_mag   = mag1_q;
    assign bus.out_quad  = quad1_q;
`endif
endmodule

// File: tb/tb_vec_quad_correct.sv
// Directed bench for vec_quad_correct (W=16, DEPTH=16); honours QUAD_GAIN_COMP_EN.
module tb_vec_quad_correct;
`ifdef QUAD_GAIN_COMP_EN
    localparam int LAT = 2;
    localparam logic [15:0] MAG_1234 = 16'h0B0D;
`else
    localparam int LAT = 1;
    localparam logic [15:0] MAG_1234 = 16'h1234;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vec_quad_correct_if #(.W(16), .DEPTH(16)) bus ();

    vec_quad_correct #(.W(16), .DEPTH(16)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.tag_valid = 1'b0;
        bus.res_valid = 1'b0;
        bus.clear_err = 1'b0;
    endtask

    task automatic push(input logic [1:0] q);
        bus.tag_valid = 1'b1;
        bus.tag_quad  = q;
        step();
        bus.tag_valid = 1'b0;
    endtask

    // Issue one result, wait out the latency and check the corrected output
    task automatic result(input string name, input logic [15:0] ang, input logic [15:0] mag,
                          input logic [15:0] exp_ang, input logic [1:0] exp_q);
        bus.res_valid = 1'b1;
        bus.res_angle = ang;
        bus.res_mag   = mag;
        step();
        bus.res_valid = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s early_valid: got %b want 0", name, bus.out_valid);
            end
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b want 1", name, bus.out_valid);
        end
        checks++;
        if (bus.out_angle !== exp_ang) begin
            errors++;
            $display("FAIL %s angle: got %h want %h", name, bus.out_angle, exp_ang);
        end
        checks++;
        if (bus.out_quad !== exp_q) begin
            errors++;
            $display("FAIL %s quad: got %b want %b", name, bus.out_quad, exp_q);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: got %b want 0", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.out_valid, bus.out_angle, bus.out_mag, bus.out_quad} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%h/%h/%b want 0", bus.out_valid, bus.out_angle,
                     bus.out_mag, bus.out_quad);
        end
        checks++;
        if ({bus.fifo_count, bus.err_overflow, bus.err_underflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got count %0d ovf %b unf %b want 0", bus.fifo_count,
                     bus.err_overflow, bus.err_underflow);
        end
        nreset = 1'b1;
        step();
    endtask

    task automatic test_correction();
        push(2'b00); push(2'b01); push(2'b11); push(2'b10);
        checks++;
        if (bus.fifo_count !== 5'd4) begin
            errors++;
            $display("FAIL corr_count: got %0d want 4", bus.fifo_count);
        end
        result("q00", 16'h2000, 16'h1234, 16'h2000, 2'b00);
        checks++;
        if (bus.out_mag !== MAG_1234) begin
            errors++;
            $display("FAIL corr_mag: got %h want %h", bus.out_mag, MAG_1234);
        end
        result("q01", 16'h2000, 16'h0001, 16'h6000, 2'b01);
        result("q11", 16'h2000, 16'h0001, 16'hA000, 2'b11);
        result("q10", 16'h2000, 16'h0001, 16'hE000, 2'b10);
    endtask

    task automatic test_boundary();
        push(2'b01); push(2'b10);
        result("pi_wrap", 16'h0000, 16'h0001, 16'h8000, 2'b01);
        result("neg_half", 16'h4000, 16'h0001, 16'hC000, 2'b10);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(2'(i));
        checks++;
        if (bus.fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_full: got %0d want 16", bus.fifo_count);
        end
        push(2'b11);
        checks++;
        if (bus.err_overflow !== 1'b1 || bus.fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_drop: got ovf %b count %0d want 1/16", bus.err_overflow, bus.fifo_count);
        end
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", bus.err_overflow);
        end
        bus.tag_valid = 1'b1;
        bus.tag_quad  = 2'b01;
        bus.res_valid = 1'b1;
        bus.res_angle = 16'h0100;
        step();
        idle();
        checks++;
        if (bus.fifo_count !== 5'd16 || bus.err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pushpop: got count %0d ovf %b want 16/0", bus.fifo_count, bus.err_overflow);
        end
        for (int i = 1; i < LAT; i++) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_quad !== 2'b00 || bus.out_angle !== 16'h0100) begin
            errors++;
            $display("FAIL ovf_pushpop_out: got %b/%b/%h want 1/00/0100", bus.out_valid,
                     bus.out_quad, bus.out_angle);
        end
        bus.res_valid = 1'b1;
        for (int i = 0; i < 16; i++) step();
        idle();
        for (int i = 0; i < LAT; i++) step();
        checks++;
        if (bus.fifo_count !== 5'd0 || bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: got count %0d unf %b want 0/0", bus.fifo_count, bus.err_underflow);
        end
    endtask

    task automatic test_underflow();
        bus.tag_valid = 1'b1;
        bus.tag_quad  = 2'b01;
        bus.res_valid = 1'b1;
        step();
        idle();
        for (int i = 0; i < LAT; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL unf_valid: got %b want 0", bus.out_valid);
            end
            if (i < LAT - 1) step();
        end
        checks++;
        if (bus.err_underflow !== 1'b1 || bus.fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL unf_flag: got unf %b count %0d want 1/1", bus.err_underflow, bus.fifo_count);
        end
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        checks++;
        if (bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: got %b want 0", bus.err_underflow);
        end
        result("unf_pushed", 16'h1000, 16'h0001, 16'h7000, 2'b01);
        bus.clear_err = 1'b1;
        bus.res_valid = 1'b1;
        step();
        idle();
        checks++;
        if (bus.err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_clear_vs_set: got %b want 1", bus.err_underflow);
        end
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        for (int i = 0; i < LAT; i++) step();
    endtask

    task automatic test_enable();
        bus.enable = 1'b0;
        push(2'b00);
        checks++;
        if (bus.fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL en_push_ignored: got %0d want 0", bus.fifo_count);
        end
        bus.enable = 1'b1;
        push(2'b11);
        result("en_q11", 16'h1000, 16'h0001, 16'h9000, 2'b11);
        push(2'b00);
        bus.enable    = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_angle = 16'h3000;
        bus.clear_err = 1'b1;
        step();
        step();
        idle();
        checks++;
        if (bus.fifo_count !== 5'd1 || bus.out_valid !== 1'b0 || bus.out_angle !== 16'h9000) begin
            errors++;
            $display("FAIL en_hold: got count %0d valid %b angle %h want 1/0/9000", bus.fifo_count,
                     bus.out_valid, bus.out_angle);
        end
        bus.enable = 1'b1;
        result("en_resume", 16'h3000, 16'h0001, 16'h3000, 2'b00);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(2'b01);
        checks++;
        if (bus.fifo_count !== 5'd5 || bus.out_angle !== 16'h3000) begin
            errors++;
            $display("FAIL rst_pre: got count %0d angle %h want 5/3000", bus.fifo_count, bus.out_angle);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_count, bus.out_valid, bus.out_angle, bus.out_mag, bus.out_quad} !== '0) begin
            errors++;
            $display("FAIL rst_async: got count %0d angle %h mag %h quad %b want 0",
                     bus.fifo_count, bus.out_angle, bus.out_mag, bus.out_quad);
        end
        nreset = 1'b1;
        step();
        bus.res_valid = 1'b1;
        step();
        idle();
        for (int i = 1; i < LAT; i++) step();
        checks++;
        if (bus.err_underflow !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_underflow: got unf %b valid %b want 1/0", bus.err_underflow, bus.out_valid);
        end
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
    endtask

`ifdef QUAD_GAIN_COMP_EN
    task automatic test_gain();
        push(2'b00);
        result("gain", 16'h1000, 16'h4000, 16'h1000, 2'b00);
        checks++;
        if (bus.out_mag !== 16'h26DD) begin
            errors++;
            $display("FAIL gain_mag: got %h want 26DD", bus.out_mag);
        end
    endtask
`endif

    initial begin
        bus.enable    = 1'b1;
        bus.tag_quad  = 2'b00;
        bus.res_angle = '0;
        bus.res_mag   = '0;
        idle();
        #3;
        test_reset();
        test_correction();
        test_boundary();
        test_overflow();
        test_underflow();
        test_enable();
        test_reset_mid();
`ifdef QUAD_GAIN_COMP_EN
        test_gain();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
